// File: rtl/fetch_queue_if.sv
// fetch_queue_if -- handshake bundle between the fetch stage, the fetch
// queue and the decode stage.
//
// Signals:
//   flush      redirect: discard every queued word at the next edge
//   in_valid   fetch stage offers {in_instr, in_pc4} this cycle
//   in_ready   queue can take a word this cycle
//   in_instr   fetched instruction word
//   in_pc4     PC+4 of the fetched instruction
//   out_valid  head entry is valid
//   out_ready  decode consumes the head this cycle
//   out_instr  head instruction (NOP when empty)
//   out_pc4    head PC+4 (0 when empty)
//   count      current occupancy, 0..2**AW
//
// Handshake: a word moves across a port on a rising clk edge where that
// port's valid and ready are both 1 and flush is 0. in_ready and out_valid
// are functions of the occupancy only, so a producer may wait on ready and
// a consumer may wait on valid without forming a combinational loop.
//
// Modports: master = the fetch/decode environment, slave = the queue.
interface fetch_queue_if #(
  parameter int AW = 2
) ();
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_instr;
  logic [31:0]   in_pc4;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc4;
  logic [AW:0]   count;

  modport master (
    output flush,
    output in_valid,
    output in_instr,
    output in_pc4,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_instr,
    input  out_pc4,
    input  count
  );

  modport slave (
    input  flush,
    input  in_valid,
    input  in_instr,
    input  in_pc4,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_instr,
    output out_pc4,
    output count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue -- instruction fetch queue between the fetch stage and decode.
//
// Buffers {instr, pc4} pairs and presents them in order through a
// first-word-fall-through valid/ready port. A branch/jump redirect (flush)
// discards every queued word.
//
// Ports:
//   clk   rising-edge clock
//   clr   asynchronous, active-high reset (pointers, count and storage to 0)
//   bus   fetch_queue_if.slave: flush, in_* handshake, out_* handshake, count
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 2)
//   AW     pointer width, log2(DEPTH)
//   NOP    instruction word shown on out_instr while the queue is empty
module fetch_queue #(
  parameter int          DEPTH = 4,
  parameter int          AW    = 2,
  parameter logic [31:0] NOP   = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               clr,
  fetch_queue_if.slave       bus
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [63:0]   mem_q [DEPTH];   // {instr, pc4}
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;

  // ---------------------------------------------------------------------------
  // Status flags: derived from count only, so neither ready nor valid ever
  // looks at the opposite handshake.
  // ---------------------------------------------------------------------------
  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // flush overrides both transfers: the word offered in a flush cycle is
  // dropped and the head is not considered consumed.
  assign push = bus.in_valid  & ~full  & ~bus.flush;
  assign pop  = bus.out_ready & ~empty & ~bus.flush;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage. Cleared on reset so nothing undefined can ever reach out_*;
  // a flush leaves contents in place since the empty flag masks them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= {bus.in_instr, bus.in_pc4};
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: first-word-fall-through, combinational from registered state.
  // A word written at edge N is visible right after edge N; there is no
  // bypass from in_* to out_* within a cycle.
  // ---------------------------------------------------------------------------
  logic [63:0] head;
  assign head = mem_q[rd_ptr_q];

  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign bus.out_instr = empty ? NOP   : head[63:32];
  assign bus.out_pc4   = empty ? '0    : head[31:0];
  assign bus.count     = count_q;

endmodule
